// File: rtl/ext_pkg.sv
// Shared types for the stream extender: extension mode and skid-buffer occupancy.
package ext_pkg;

   typedef enum logic {
      EXT_SIGN = 1'b0,
      EXT_ZERO = 1'b1
   } ext_mode_e;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_FULL
   } buf_state_e;

endpackage

// File: rtl/ext_lane.sv
// Single-element extend-and-scale: sign/zero extend to OUT_SIZE, then left shift
// by a clamped amount so the result can never overflow.
module ext_lane
   import ext_pkg::*;
#(
   parameter int IN_SIZE  = 4,
   parameter int OUT_SIZE = 8,
   parameter int SH_W     = 3
) (
   input  logic [IN_SIZE-1:0]  x,
   input  ext_mode_e           mode,
   input  logic [SH_W-1:0]     shift,
   output logic [OUT_SIZE-1:0] y
);

   localparam logic [SH_W-1:0] MAX_SH = SH_W'(OUT_SIZE - IN_SIZE);

   logic                fill_bit;
   logic [OUT_SIZE-1:0] ext_val;
   logic [SH_W-1:0]     sh_clamped;

   assign fill_bit   = (mode == EXT_SIGN) & x[IN_SIZE-1];
   assign ext_val    = {{(OUT_SIZE-IN_SIZE){fill_bit}}, x};
   assign sh_clamped = (shift > MAX_SH) ? MAX_SH : shift;
   assign y          = ext_val << sh_clamped;

endmodule

// File: rtl/stream_extender.sv
// Multi-lane stream widener with valid/ready handshake, registered ready and a
// 2-entry skid buffer that stores only already-extended results.
module stream_extender
   import ext_pkg::*;
#(
   parameter int N_LANES  = 4,
   parameter int IN_SIZE  = 4,
   parameter int OUT_SIZE = 8,
   parameter int CNT_W    = 16,
   localparam int SH_W    = $clog2(OUT_SIZE - IN_SIZE + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [N_LANES*IN_SIZE-1:0]   in_data_i,
   input  logic                         in_mode_i,
   input  logic [SH_W-1:0]              in_shift_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [N_LANES*OUT_SIZE-1:0]  out_data_o,
   output logic [CNT_W-1:0]             xfer_cnt_o
);

   localparam int OW = N_LANES * OUT_SIZE;

   logic [OW-1:0]    ext_data;
   logic [OW-1:0]    head_reg;
   logic [OW-1:0]    tail_reg;
   buf_state_e       state_reg;
   logic             ready_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             in_xfer;
   logic             out_xfer;

   for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      ext_lane #(
         .IN_SIZE  (IN_SIZE),
         .OUT_SIZE (OUT_SIZE),
         .SH_W     (SH_W)
      ) u_lane (
         .x     (in_data_i[gi*IN_SIZE +: IN_SIZE]),
         .mode  (ext_mode_e'(in_mode_i)),
         .shift (in_shift_i),
         .y     (ext_data[gi*OUT_SIZE +: OUT_SIZE])
      );
   end

   assign in_xfer     = in_valid_i && ready_reg;
   assign out_valid_o = (state_reg != BUF_EMPTY);
   assign out_xfer    = out_valid_o && out_ready_i;
   assign in_ready_o  = ready_reg;
   assign out_data_o  = head_reg;
   assign xfer_cnt_o  = cnt_reg;

   // head_reg is always the oldest entry; tail_reg is only live in BUF_FULL.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= BUF_EMPTY;
         ready_reg <= 1'b1;
         head_reg  <= '0;
         tail_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         if (out_xfer)
            cnt_reg <= cnt_reg + 1'b1;
         case (state_reg)
            BUF_EMPTY: begin
               if (in_xfer) begin
                  head_reg  <= ext_data;
                  state_reg <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (in_xfer && out_xfer) begin
                  head_reg <= ext_data;
               end else if (in_xfer) begin
                  tail_reg  <= ext_data;
                  state_reg <= BUF_FULL;
                  ready_reg <= 1'b0;
               end else if (out_xfer) begin
                  state_reg <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (out_xfer) begin
                  head_reg  <= tail_reg;
                  state_reg <= BUF_ONE;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= BUF_EMPTY;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/stream_extender.md
Name: stream_extender

Overview:
- Multi-lane streaming extender. Widens N_LANES packed elements from IN_SIZE to OUT_SIZE bits per transfer.
- Per-transfer mode selects sign or zero extension. An optional left-scale aligns fixed-point data into the wider accumulator format.
- Sits between the operand fetch stream and the MAC array. It has a valid/ready handshake, a registered ready and a 2-entry skid buffer, so it can be placed on timing-critical stream boundaries.

Parameters:
- N_LANES, 4, number of elements per transfer.
- IN_SIZE, 4, input element width in bits (>=2).
- OUT_SIZE, 8, output element width in bits (> IN_SIZE).
- SH_W, $clog2(OUT_SIZE-IN_SIZE+1), width of the scale field (derived, not to be overridden).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  input transfer valid.
- in_ready_o  out  1  input transfer ready (registered).
- in_data_i  in  N_LANES*IN_SIZE  packed elements, lane 0 in LSBs.
- in_mode_i  in  1  0 = sign extend, 1 = zero extend.
- in_shift_i  in  SH_W  left-scale amount, legal range 0..OUT_SIZE-IN_SIZE.
- out_valid_o  out  1  output transfer valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  N_LANES*OUT_SIZE  packed extended elements, lane 0 in LSBs.
- xfer_cnt_o  out  CNT_W  number of completed output transfers.

Behaviour:
- Per-lane function:
  - e = mode ? zero-extend(x) : sign-extend(x), to OUT_SIZE bits.
  - Result = e << shift, truncated to OUT_SIZE.
  - Because shift <= OUT_SIZE-IN_SIZE, the result is exact and never overflows.
  - Shift values above OUT_SIZE-IN_SIZE are clamped to OUT_SIZE-IN_SIZE.
- Computation happens on the input side. Only extended results are stored; raw inputs are not.
- Transfers:
  - Input transfer: in_valid_i && in_ready_o.
  - Output transfer: out_valid_o && out_ready_i.
- Storage is a 2-entry buffer with states EMPTY, ONE and FULL.
  - EMPTY: in xfer -> ONE.
  - ONE: in xfer without out xfer -> FULL. Out xfer without in xfer -> EMPTY. Both -> ONE (the new entry replaces the old one).
  - FULL: out xfer -> ONE. No in xfer is possible in FULL.
- Output flags:
  - in_ready_o = (state != FULL), driven from a register.
  - out_valid_o = (state != EMPTY).
- Latency: 1 cycle from input transfer to out_valid_o when the buffer is empty. Throughput is 1 transfer per cycle while out_ready_i is held high.
- Ordering is strictly FIFO. out_data_o always presents the oldest entry. Data is stable while out_valid_o && !out_ready_i.
- xfer_cnt_o increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Reset values: out_valid_o=0, in_ready_o=1, out_data_o=0, xfer_cnt_o=0, state EMPTY.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronously); no partial transfer is emitted.
- out_ready_i asserted while EMPTY: no effect.
- in_valid_i deasserted without a transfer: allowed, no effect.

Decomposition:
- Shared package ext_pkg holds:
  - typedef enum logic {EXT_SIGN=1'b0, EXT_ZERO=1'b1} ext_mode_e.
  - typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_e.
- One sub-module, ext_lane: combinational single-element extend-and-shift, with parameters IN_SIZE, OUT_SIZE and SH_W. Instantiated N_LANES times via generate.
- The skid buffer and counter stay in the top module.

Test Plan:
- Default parameters, sign mode, shift 0, in_data_i=16'hF872 (lanes 2,7,8,F), out_ready_i=1.
  - Required: out_data_o=32'hFFF80702 one cycle later.
  - Required: xfer_cnt_o becomes 1 on the cycle that transfer completes.
- Zero mode, shift 0, same data.
  - Required: out_data_o=32'h0F080702.
- Sign mode, shift 4, in_data_i=16'h0008.
  - Required: lane 0=8'h80, other lanes 8'h00.
- Shift clamp: shift 7 (above the legal max of 4).
  - Required: same result as shift 4.
- Backpressure: out_ready_i=0, push 3 transfers A, B, C.
  - Required: A and B accepted. in_ready_o goes low the cycle after B. C is held.
  - Then out_ready_i=1: outputs A, B, C in order, with no duplicates or drops.
  - Required: xfer_cnt_o ends at 3.
- Reset mid-stream: assert rst_i while FULL.
  - Required: out_valid_o=0, in_ready_o=1, xfer_cnt_o=0 immediately, with no clock edge required.
- Wrap-around: CNT_W=4, stream 17 transfers back-to-back.
  - Required: xfer_cnt_o=1 at the end.
  - Required: sustained throughput of 1 per cycle, checked with random ready/valid and a scoreboard.
